secure_storage_mp: RTL
======================

# secure_storage_mp

Parametrised, region-protected storage array with deny-by-default permissions and a valid/ready request/response interface. The address space is split into `NUM_REGIONS` equal regions. Each region has its own read/write permission bits and a sticky lock bit, programmed through a privileged configuration port. The block sits between bus-side masters and on-chip secret storage, and it flags every denied access.

## Interface
- `DATA_W`, 32: word width.
- `ADDR_W`, 8: address width; depth = 2**ADDR_W words.
- `NUM_REGIONS`, 4: power of two, 1..2**ADDR_W.
- `CNT_W`, 8: width of the violation counter.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  DATA_W  read data; 0 on writes and on errors.
- `rsp_err`  out  1  access denied.
- `cfg_valid`  in  1  configuration strobe.
- `cfg_priv`  in  1  requester is privileged.
- `cfg_region`  in  $clog2(NUM_REGIONS) (min 1)  target region.
- `cfg_perm`  in  2  {W,R} permission bits.
- `cfg_lock`  in  1  set the region's lock bit.
- `cfg_err`  out  1  one-cycle pulse marking a rejected configuration.
- `viol_count`  out  CNT_W  saturating count of denied requests.

## Operation
- Region index = top $clog2(NUM_REGIONS) bits of `req_addr`. When NUM_REGIONS = 1, the index is always 0.
- Reset:
  - All permissions are 2'b00 (deny all).
  - All locks are 0, state is IDLE, `viol_count` is 0.
  - `rsp_valid`, `rsp_err`, `cfg_err` are 0 and `rsp_rdata` is 0.
  - Array contents are not reset.
- FSM has two states, IDLE and RESP.
  - IDLE → RESP when a request is accepted (`req_valid & req_ready`).
  - RESP → IDLE when `rsp_valid & rsp_ready`.
- At the accept edge:
  - Write with W=1: the array word is updated and the response carries `rsp_err`=0.
  - Read with R=1: `rsp_rdata` is loaded with the array word.
  - Denied access: the array is unchanged, `rsp_rdata`=0, `rsp_err`=1, and `viol_count` increments, saturating at all-ones.
- Response stability: `rsp_valid`, `rsp_rdata` and `rsp_err` hold stable while `rsp_valid & !rsp_ready`.
- Configuration, evaluated every cycle independent of the FSM:
  - `cfg_valid & cfg_priv & !lock[region]`: perm[region] ← `cfg_perm`, and lock[region] ← lock[region] | `cfg_lock`.
  - `cfg_valid` with `!cfg_priv`, or to a locked region: no state change and `cfg_err`=1 for one cycle.
  - A lock can only be cleared by reset.
- Simultaneous config and request accept in the same cycle: the request is checked against the pre-update permissions.

## Timing
- Request accepted at edge T → `rsp_valid`=1 from T+1.
- Back-to-back throughput is one request per 2 cycles when `rsp_ready` is held high.
- `req_ready` is a pure function of state (IDLE); it has no combinational path from `req_valid`.
- Config takes effect at the edge where `cfg_valid` is sampled. It is visible to requests accepted at the following edge.
- `cfg_err` is registered and asserts one cycle after the offending `cfg_valid`.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronously).
  - A pending response is dropped.
  - An in-flight write at the same edge does not occur.

## Structure
- Package `secure_storage_pkg`:
  - `perm_t` = struct {w, r}.
  - `state_t` enum {IDLE, RESP}.
  - constants `PERM_NONE`=2'b00, `PERM_RW`=2'b11.
- Sub-module `region_perm_regs`:
  - Holds the permission and lock arrays and the config/`cfg_err` logic.
  - Exposes a combinational lookup port: region in → perm out.
- The top holds the array, FSM, response registers and violation counter.

## Test plan
- After reset, read addr 0x10 → `rsp_err`=1, `rsp_rdata`=0, `viol_count`=1; write 0xDEADBEEF to 0x10 → `rsp_err`=1, array unchanged.
- Privileged config region 0 perm=2'b11, then write 0xDEADBEEF to 0x10 and read it back → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Config region 1 perm=2'b01 with lock=1, then unprivileged and privileged attempts to set perm=2'b11 → `cfg_err` pulses both times; write to 0x50 is denied; read of 0x50 is allowed.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0; a new `req_valid` is not accepted until the handshake completes.
- Same cycle: accepted write to 0x90 and config granting region 2 W → the write is denied (old perms); a repeat write succeeds.
- Issue 300 denied requests with `CNT_W`=8 → `viol_count` saturates at 255. Asserting `rst_n`=0 during RESP → `rsp_valid`=0 immediately; after release, perms and locks are cleared.

Source files
------------

// File: rtl/secure_storage_pkg.sv
// Shared types and constants for the region-protected storage block.
// Permissions are {w,r}; the response FSM has two states.
package secure_storage_pkg;

  typedef struct packed {
    logic w;
    logic r;
  } perm_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [1:0] PERM_NONE = 2'b00;
  localparam logic [1:0] PERM_RW   = 2'b11;

endpackage

// File: rtl/region_perm_regs.sv
// Per-region permission and sticky lock registers with the config port.
// Provides a combinational region -> permission lookup for the datapath.
module region_perm_regs
  import secure_storage_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int RW          = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic          cfg_priv,
  input  logic [RW-1:0] cfg_region,
  input  logic [1:0]    cfg_perm,
  input  logic          cfg_lock,
  output logic          cfg_err,
  input  logic [RW-1:0] lk_region,
  output perm_t         lk_perm
);

  perm_t            r_perm [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] r_lock;
  logic             r_cfg_err;
  logic [RW-1:0]    w_cidx;
  logic [RW-1:0]    w_lidx;
  logic             w_ok;

  generate
    if (NUM_REGIONS == 1) begin : g_one
      assign w_cidx = '0;
      assign w_lidx = '0;
    end else begin : g_many
      assign w_cidx = cfg_region;
      assign w_lidx = lk_region;
    end
  endgenerate

  assign w_ok = cfg_valid & cfg_priv & ~r_lock[w_cidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        r_perm[i] <= perm_t'(PERM_NONE);
      r_lock    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_valid & ~w_ok;
      if (w_ok) begin
        r_perm[w_cidx] <= perm_t'(cfg_perm);
        r_lock[w_cidx] <= r_lock[w_cidx] | cfg_lock;
      end
    end
  end

  assign lk_perm = r_perm[w_lidx];
  assign cfg_err = r_cfg_err;

endmodule

// File: rtl/secure_storage_mp.sv
// Region-protected storage array with valid/ready request/response
// handshake, deny-by-default permissions and a violation counter.
module secure_storage_mp
  import secure_storage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_W       = 8,
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              cfg_valid,
  input  logic              cfg_priv,
  input  logic [RW-1:0]     cfg_region,
  input  logic [1:0]        cfg_perm,
  input  logic              cfg_lock,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  viol_count
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_viol;
  logic [RW-1:0]     w_region;
  perm_t             w_perm;
  logic              w_acc;
  logic              w_deny;

  generate
    if (NUM_REGIONS == 1) begin : g_one
      assign w_region = '0;
    end else begin : g_many
      assign w_region = req_addr[ADDR_W-1 -: RW];
    end
  endgenerate

  region_perm_regs #(
    .NUM_REGIONS (NUM_REGIONS),
    .RW          (RW)
  ) u_perm (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_priv   (cfg_priv),
    .cfg_region (cfg_region),
    .cfg_perm   (cfg_perm),
    .cfg_lock   (cfg_lock),
    .cfg_err    (cfg_err),
    .lk_region  (w_region),
    .lk_perm    (w_perm)
  );

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign w_acc     = req_valid & req_ready;
  assign w_deny    = req_write ? ~w_perm.w : ~w_perm.r;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Storage is not reset; gating on rst_n blocks a write racing reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_acc && req_write && !w_deny)
      r_mem[req_addr] <= req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_rdata <= (!req_write && !w_deny) ? r_mem[req_addr] : '0;
      r_err   <= w_deny;
    end else if (rsp_valid && rsp_ready) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_viol <= '0;
    else if (w_acc && w_deny && (r_viol != '1))
      r_viol <= r_viol + CNT_W'(1);
  end

  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign viol_count = r_viol;

endmodule
